// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, data width, and the command driver's channel,
// FSM state and command record definitions.
package alu_pkg;

    typedef enum logic [1:0] {
        OP1 = 2'd0,
        OP2 = 2'd1,
        OP3 = 2'd2,
        OP4 = 2'd3
    } opcode_t;

    typedef logic [7:0] data_t;

    typedef enum logic {
        CHAN_A = 1'b0,
        CHAN_B = 1'b1
    } chan_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        CLEAR  = 3'd3,
        RESP   = 3'd4
    } drv_state_t;

    typedef struct packed {
        chan_t   chan;
        opcode_t op;
        data_t   a;
        data_t   b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; the head entry
// is visible on pop_data whenever the FIFO is non-empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic     alu_clk,
    input  logic     alu_rst,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(CMD_DEPTH);

    alu_cmd_t         mem_r [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the flags and compute the next occupancy
    always_comb begin
        push_ok_s   = push & ~full;
        pop_ok_s    = pop & ~empty;
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_nxt_s = count_r - (PTR_W+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array, written at the tail
    always_ff @(posedge alu_clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and flags; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge alu_clk) begin
        if (alu_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full    <= (count_nxt_s == (PTR_W+1)'(CMD_DEPTH));
            empty   <= (count_nxt_s == (PTR_W+1)'(0));
        end
    end

    assign pop_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/alu_cmd_driver.sv
// ALU command initiator: queues host commands, drives one at a time onto the
// ALU channel controls, clears raised IRQs and returns each result.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             alu_clk,
    input  logic             alu_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_chan,
    input  opcode_t          cmd_op,
    input  data_t            cmd_a,
    input  data_t            cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output data_t            rsp_data,
    output logic             rsp_irq,
    output logic             alu_enable,
    output logic             alu_enable_a,
    output logic             alu_enable_b,
    output opcode_t          alu_op_a,
    output opcode_t          alu_op_b,
    output data_t            alu_in_a,
    output data_t            alu_in_b,
    output logic             alu_irq_clr,
    input  data_t            alu_out,
    input  logic             alu_irq,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] irq_cnt
);

    alu_cmd_t   push_cmd_s;
    alu_cmd_t   head_cmd_s;
    logic       push_s;
    logic       pop_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;
    drv_state_t state_r;

    // Pack the host command and derive FIFO handshakes
    always_comb begin
        push_cmd_s = '{chan: chan_t'(cmd_chan), op: cmd_op, a: cmd_a, b: cmd_b};
        push_s     = cmd_valid & ~fifo_full_s;
        if ((state_r == IDLE) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign cmd_ready = ~fifo_full_s;

    alu_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_fifo (
        .alu_clk   (alu_clk),
        .alu_rst   (alu_rst),
        .push      (push_s),
        .push_data (push_cmd_s),
        .pop       (pop_s),
        .pop_data  (head_cmd_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Command sequencer with all ALU-facing and response outputs registered
    always_ff @(posedge alu_clk) begin
        if (alu_rst) begin
            state_r      <= IDLE;
            alu_enable   <= 1'b0;
            alu_enable_a <= 1'b0;
            alu_enable_b <= 1'b0;
            alu_op_a     <= OP1;
            alu_op_b     <= OP1;
            alu_in_a     <= 8'h00;
            alu_in_b     <= 8'h00;
            alu_irq_clr  <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            rsp_irq      <= 1'b0;
            done_cnt     <= '0;
            irq_cnt      <= '0;
        end else begin
            // Clear strobe is one cycle wide unless SAMPLE raises it again
            alu_irq_clr <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        alu_enable <= 1'b1;
                        if (head_cmd_s.chan == CHAN_A) begin
                            alu_enable_a <= 1'b1;
                            alu_enable_b <= 1'b0;
                            alu_op_a     <= head_cmd_s.op;
                        end else begin
                            alu_enable_a <= 1'b0;
                            alu_enable_b <= 1'b1;
                            alu_op_b     <= head_cmd_s.op;
                        end
                        alu_in_a <= head_cmd_s.a;
                        alu_in_b <= head_cmd_s.b;
                        state_r  <= DRIVE;
                    end
                end
                DRIVE: begin
                    alu_enable   <= 1'b0;
                    alu_enable_a <= 1'b0;
                    alu_enable_b <= 1'b0;
                    state_r      <= SAMPLE;
                end
                SAMPLE: begin
                    rsp_data <= alu_out;
                    rsp_irq  <= alu_irq;
                    if (alu_irq) begin
                        irq_cnt     <= irq_cnt + CNT_W'(1);
                        alu_irq_clr <= 1'b1;
                        state_r     <= CLEAR;
                    end else begin
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                CLEAR: begin
                    rsp_valid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    alu_enable   <= 1'b0;
                    alu_enable_a <= 1'b0;
                    alu_enable_b <= 1'b0;
                    rsp_valid    <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: stub XOR ALU plus a queue-based expectation model.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int CNT_W = 8;

    logic             alu_clk = 1'b0;
    logic             alu_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_chan = 1'b0;
    opcode_t          cmd_op = OP1;
    data_t            cmd_a = 8'h00;
    data_t            cmd_b = 8'h00;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    data_t            rsp_data;
    logic             rsp_irq;
    logic             alu_enable, alu_enable_a, alu_enable_b;
    opcode_t          alu_op_a, alu_op_b;
    data_t            alu_in_a, alu_in_b;
    logic             alu_irq_clr;
    data_t            alu_out = 8'h00;
    logic             alu_irq = 1'b0;
    logic [CNT_W-1:0] done_cnt, irq_cnt;

    logic irq_force = 1'b0;
    logic irq_rand_en = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_exp = 0;
    int irq_exp = 0;
    data_t exp_data_q[$];
    logic  exp_irq_q[$];
    opcode_t last_op_a, last_op_b;
    logic seen_a = 1'b0, seen_b = 1'b0;

    always #5 alu_clk = ~alu_clk;

    alu_cmd_driver #(.CMD_DEPTH(4), .CNT_W(CNT_W)) dut (
        .alu_clk(alu_clk), .alu_rst(alu_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_irq(rsp_irq),
        .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
        .done_cnt(done_cnt), .irq_cnt(irq_cnt)
    );

    // Stub ALU: result and IRQ latch one edge after any enable; clear drops the IRQ
    always @(posedge alu_clk) begin
        if (alu_enable | alu_enable_a | alu_enable_b) begin
            alu_out <= alu_in_a ^ alu_in_b;
            alu_irq <= irq_force | (irq_rand_en & alu_in_a[0]);
        end else if (alu_irq_clr) begin
            alu_irq <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge alu_clk);
        #1;
    endtask

    // Offer one command, wait for acceptance and record what the ALU should return
    task automatic push_cmd(input logic ch, input opcode_t op, input data_t a, input data_t b);
        int n = 0;
        cmd_valid = 1'b1; cmd_chan = ch; cmd_op = op; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout cmd_ready stayed 0 for %0d cycles", n);
        end else begin
            tick();
            exp_data_q.push_back(a ^ b);
            exp_irq_q.push_back(irq_force | (irq_rand_en & a[0]));
            if (ch == 1'b0) begin last_op_a = op; seen_a = 1'b1; end
            else begin last_op_b = op; seen_b = 1'b1; end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        alu_rst = 1'b1;
        repeat (3) tick();
        checks++; if (alu_irq_clr !== 1'b1) begin failures++; $display("FAIL rst_irq_clr got=%0b exp=1", alu_irq_clr); end
        checks++; if ({alu_enable, alu_enable_a, alu_enable_b} !== 3'b000) begin failures++; $display("FAIL rst_enables got=%b exp=000", {alu_enable, alu_enable_a, alu_enable_b}); end
        checks++; if (alu_op_a !== OP1 || alu_op_b !== OP1) begin failures++; $display("FAIL rst_ops got=%0d/%0d exp=0/0", alu_op_a, alu_op_b); end
        checks++; if (alu_in_a !== 8'h00 || alu_in_b !== 8'h00) begin failures++; $display("FAIL rst_ins got=%h/%h exp=00/00", alu_in_a, alu_in_b); end
        alu_rst = 1'b0;
        tick();
        checks++; if (alu_irq_clr !== 1'b0) begin failures++; $display("FAIL rst_release_clr got=%0b exp=0", alu_irq_clr); end
        repeat (5) tick();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%0b exp=1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_rsp_valid got=%0b exp=0", rsp_valid); end
        checks++; if (done_cnt !== '0 || irq_cnt !== '0) begin failures++; $display("FAIL idle_counters got=%0d/%0d exp=0/0", done_cnt, irq_cnt); end
        checks++; if (rsp_data !== 8'h00 || rsp_irq !== 1'b0) begin failures++; $display("FAIL idle_rsp got=%h/%0b exp=00/0", rsp_data, rsp_irq); end
    endtask

    task automatic test_chan_a();
        int en_a = 0, en_b = 0, lat = 0;
        data_t got_d = 8'h00;
        logic got_i = 1'b1;
        rsp_ready = 1'b1;
        push_cmd(1'b0, OP4, 8'h0F, 8'hF0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (alu_enable_a) en_a++;
            if (alu_enable_b) en_b++;
            if (rsp_valid && lat == 0) begin lat = k; got_d = rsp_data; got_i = rsp_irq; end
        end
        checks++; if (en_a != 1 || en_b != 0) begin failures++; $display("FAIL a_enable_cycles got=%0d/%0d exp=1/0", en_a, en_b); end
        checks++; if (lat != 3) begin failures++; $display("FAIL a_latency got=%0d exp=3", lat); end
        checks++; if (got_d !== 8'hFF || got_i !== 1'b0) begin failures++; $display("FAIL a_rsp got=%h/%0b exp=ff/0", got_d, got_i); end
        checks++; if (done_cnt !== CNT_W'(1)) begin failures++; $display("FAIL a_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (alu_op_a !== OP4 || alu_in_a !== 8'h0F || alu_in_b !== 8'hF0) begin failures++; $display("FAIL a_retain got=%0d/%h/%h exp=3/0f/f0", alu_op_a, alu_in_a, alu_in_b); end
        done_exp = 1;
        exp_data_q.delete(); exp_irq_q.delete();
    endtask

    task automatic test_chan_b_irq();
        int en_a = 0, en_b = 0, clr = 0, lat = 0;
        data_t got_d = 8'h00;
        logic got_i = 1'b0;
        irq_force = 1'b1;
        push_cmd(1'b1, OP2, 8'hAA, 8'h55);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (alu_enable_a) en_a++;
            if (alu_enable_b) en_b++;
            if (alu_irq_clr) clr++;
            if (rsp_valid && lat == 0) begin lat = k; got_d = rsp_data; got_i = rsp_irq; end
        end
        irq_force = 1'b0;
        checks++; if (en_a != 0 || en_b != 1) begin failures++; $display("FAIL b_enable_cycles got=%0d/%0d exp=0/1", en_a, en_b); end
        checks++; if (clr != 1) begin failures++; $display("FAIL b_clr_cycles got=%0d exp=1", clr); end
        checks++; if (lat != 4) begin failures++; $display("FAIL b_latency got=%0d exp=4", lat); end
        checks++; if (got_d !== 8'hFF || got_i !== 1'b1) begin failures++; $display("FAIL b_rsp got=%h/%0b exp=ff/1", got_d, got_i); end
        checks++; if (irq_cnt !== CNT_W'(1) || done_cnt !== CNT_W'(2)) begin failures++; $display("FAIL b_counters got=%0d/%0d exp=1/2", irq_cnt, done_cnt); end
        checks++; if (alu_op_b !== OP2 || alu_op_a !== OP4) begin failures++; $display("FAIL b_ops got=%0d/%0d exp=1/3", alu_op_b, alu_op_a); end
        done_exp = 2; irq_exp = 1;
        exp_data_q.delete(); exp_irq_q.delete();
    endtask

    task automatic test_backpressure();
        int recv = 0, cyc = 0;
        irq_rand_en = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_cmd(1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 3)), data_t'($urandom), data_t'($urandom));
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=%0b exp=0", cmd_ready); end
        repeat (6) tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data_q[0]) begin failures++; $display("FAIL bp_hold got=%0b/%h exp=1/%h", rsp_valid, rsp_data, exp_data_q[0]); end
        rsp_ready = 1'b1;
        while (recv < 5 && cyc < 100) begin
            if (rsp_valid) begin
                checks++;
                if (exp_data_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", rsp_data); end
                else begin
                    if (rsp_data !== exp_data_q[0] || rsp_irq !== exp_irq_q[0]) begin
                        failures++; $display("FAIL bp_rsp%0d got=%h/%0b exp=%h/%0b", recv, rsp_data, rsp_irq, exp_data_q[0], exp_irq_q[0]);
                    end
                    if (exp_irq_q[0]) irq_exp++;
                    void'(exp_data_q.pop_front()); void'(exp_irq_q.pop_front());
                end
                recv++; done_exp++;
            end
            tick(); cyc++;
        end
        repeat (8) tick();
        checks++; if (recv != 5 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_count got=%0d exp=5", recv); end
        checks++; if (done_cnt !== CNT_W'(done_exp) || irq_cnt !== CNT_W'(irq_exp)) begin failures++; $display("FAIL bp_counters got=%0d/%0d exp=%0d/%0d", done_cnt, irq_cnt, done_exp, irq_exp); end
        irq_rand_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int saw_v = 0, saw_en = 0, cyc = 0;
        logic got = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, OP3, data_t'($urandom), data_t'($urandom));
        alu_rst = 1'b1;
        tick();
        alu_rst = 1'b0;
        exp_data_q.delete(); exp_irq_q.delete();
        done_exp = 0; irq_exp = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid) saw_v++;
            if (alu_enable | alu_enable_a | alu_enable_b) saw_en++;
        end
        checks++; if (saw_v != 0) begin failures++; $display("FAIL mid_no_rsp got=%0d exp=0", saw_v); end
        checks++; if (saw_en != 0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL mid_fifo_empty got=%0d/%0b exp=0/1", saw_en, cmd_ready); end
        checks++; if (done_cnt !== '0 || irq_cnt !== '0) begin failures++; $display("FAIL mid_counters got=%0d/%0d exp=0/0", done_cnt, irq_cnt); end
        push_cmd(1'b1, OP1, 8'h3C, 8'h81);
        while (!got && cyc < 20) begin
            tick(); cyc++;
            if (rsp_valid) begin
                got = 1'b1;
                checks++; if (rsp_data !== 8'hBD || rsp_irq !== 1'b0) begin failures++; $display("FAIL mid_next_rsp got=%h/%0b exp=bd/0", rsp_data, rsp_irq); end
            end
        end
        checks++; if (!got) begin failures++; $display("FAIL mid_next_timeout got=none exp=response"); end
        exp_data_q.delete(); exp_irq_q.delete();
        done_exp = 1;
        tick();
    endtask

    task automatic test_random();
        int n_cmd = 24, recv = 0, cyc = 0;
        irq_rand_en = 1'b1;
        seen_a = 1'b0; seen_b = 1'b0;
        fork
            begin
                for (int i = 0; i < n_cmd; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    push_cmd(1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 3)), data_t'($urandom), data_t'($urandom));
                end
            end
            begin
                while (recv < n_cmd && cyc < 3000) begin
                    rsp_ready = 1'($urandom_range(0, 1));
                    if (rsp_valid && rsp_ready) begin
                        checks++;
                        if (exp_data_q.size() == 0) begin failures++; $display("FAIL rnd_extra got=%h exp=none", rsp_data); end
                        else begin
                            if (rsp_data !== exp_data_q[0] || rsp_irq !== exp_irq_q[0]) begin
                                failures++; $display("FAIL rnd_rsp%0d got=%h/%0b exp=%h/%0b", recv, rsp_data, rsp_irq, exp_data_q[0], exp_irq_q[0]);
                            end
                            if (exp_irq_q[0]) irq_exp++;
                            void'(exp_data_q.pop_front()); void'(exp_irq_q.pop_front());
                        end
                        recv++; done_exp++;
                    end
                    tick(); cyc++;
                end
            end
        join
        rsp_ready = 1'b1;
        repeat (4) tick();
        checks++; if (recv != n_cmd) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", recv, n_cmd); end
        checks++; if (done_cnt !== CNT_W'(done_exp) || irq_cnt !== CNT_W'(irq_exp)) begin failures++; $display("FAIL rnd_counters got=%0d/%0d exp=%0d/%0d", done_cnt, irq_cnt, done_exp, irq_exp); end
        if (seen_a) begin
            checks++; if (alu_op_a !== last_op_a) begin failures++; $display("FAIL rnd_op_a got=%0d exp=%0d", alu_op_a, last_op_a); end
        end
        if (seen_b) begin
            checks++; if (alu_op_b !== last_op_b) begin failures++; $display("FAIL rnd_op_b got=%0d exp=%0d", alu_op_b, last_op_b); end
        end
        irq_rand_en = 1'b0;
    endtask

    task automatic test_wrap();
        int m = (1 << CNT_W) - (done_exp % (1 << CNT_W));
        int recv = 0, cyc = 0;
        rsp_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < m; i++) push_cmd(1'($urandom_range(0, 1)), OP1, data_t'($urandom), data_t'($urandom));
            end
            begin
                while (recv < m && cyc < 8 * m + 100) begin
                    if (rsp_valid) begin
                        recv++;
                        void'(exp_data_q.pop_front()); void'(exp_irq_q.pop_front());
                    end
                    tick(); cyc++;
                end
            end
        join
        done_exp += recv;
        repeat (2) tick();
        checks++; if (recv != m) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", recv, m); end
        checks++; if (done_cnt !== CNT_W'(0)) begin failures++; $display("FAIL wrap_done_cnt got=%0d exp=0", done_cnt); end
        checks++; if (irq_cnt !== CNT_W'(irq_exp)) begin failures++; $display("FAIL wrap_irq_cnt got=%0d exp=%0d", irq_cnt, irq_exp); end
    endtask

    initial begin
        test_reset();
        test_chan_a();
        test_chan_b_irq();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
